// File: rtl/ras_repair_ctrl.sv
// Return-address-stack checkpoint buffer: snapshots RAS pointer/top per predicted
// branch and, on a mispredict, rewrites the RAS from the flushed branch's snapshot.
module ras_repair_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       alloc_vld_i,
    input  logic [3:0]                 ras_ptr_i,
    input  logic [63:0]                ras_top_i,
    output logic                       alloc_rdy_o,
    output logic [$clog2(DEPTH)-1:0]   alloc_tag_o,
    input  logic                       retire_vld_i,
    input  logic                       flush_vld_i,
    input  logic [$clog2(DEPTH)-1:0]   flush_tag_i,
    output logic                       ras_wr_en_o,
    output logic [3:0]                 ras_wr_idx_o,
    output logic [63:0]                ras_wr_data_o,
    output logic                       ras_ptr_rst_vld_o,
    output logic [3:0]                 ras_ptr_rst_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int TW = $clog2(DEPTH);

    typedef enum logic {IDLE, REPAIR} state_t;

    state_t          state_q, state_d;
    logic [TW:0]     head_q, head_d;
    logic [TW:0]     tail_q, tail_d;
    logic [3:0]      rep_ptr_q, rep_ptr_d;
    logic [63:0]     rep_data_q, rep_data_d;
    logic [67:0]     mem_q [DEPTH];

    logic            empty, full, alloc_fire, flush_hit;
    logic [TW:0]     count_w, flush_pos;
    logic [TW-1:0]   flush_off;
    logic [67:0]     flush_entry;

    assign count_w    = tail_q - head_q;
    assign empty      = (head_q == tail_q);
    assign full       = (head_q[TW-1:0] == tail_q[TW-1:0]) && (head_q[TW] != tail_q[TW]);
    assign alloc_rdy_o = ~full & (state_q == IDLE) & ~flush_vld_i;
    assign alloc_fire = alloc_vld_i & alloc_rdy_o;
    assign alloc_tag_o = tail_q[TW-1:0];

    // Distance of the flushed tag from head; live iff it falls below the occupancy.
    assign flush_off   = flush_tag_i - head_q[TW-1:0];
    assign flush_hit   = ({1'b0, flush_off} < count_w);
    assign flush_pos   = head_q + {1'b0, flush_off};
    assign flush_entry = mem_q[flush_tag_i];

    always_comb begin
        state_d    = IDLE;
        head_d     = head_q;
        tail_d     = tail_q;
        rep_ptr_d  = rep_ptr_q;
        rep_data_d = rep_data_q;
        if (retire_vld_i && !empty) begin
            head_d = head_q + 1'b1;
        end
        if (alloc_fire) begin
            tail_d = tail_q + 1'b1;
        end
        if (state_q == IDLE && flush_vld_i) begin
            if (flush_hit) begin
                tail_d     = flush_pos + 1'b1;
                state_d    = REPAIR;
                rep_ptr_d  = flush_entry[67:64];
                rep_data_d = flush_entry[63:0];
            end else begin
                // Unknown tag: nothing younger than head can be trusted.
                tail_d = head_d;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Payload storage carries no reset; outputs are gated by the FSM state.
    always_ff @(posedge clock) begin
        rep_ptr_q  <= rep_ptr_d;
        rep_data_q <= rep_data_d;
        if (alloc_fire) begin
            mem_q[tail_q[TW-1:0]] <= {ras_ptr_i, ras_top_i};
        end
    end

    assign ras_wr_en_o       = (state_q == REPAIR);
    assign ras_ptr_rst_vld_o = (state_q == REPAIR);
    assign busy_o            = (state_q == REPAIR);
    assign ras_wr_idx_o      = (state_q == REPAIR) ? rep_ptr_q  : 4'd0;
    assign ras_ptr_rst_o     = (state_q == REPAIR) ? rep_ptr_q  : 4'd0;
    assign ras_wr_data_o     = (state_q == REPAIR) ? rep_data_q : 64'd0;
    assign count_o           = count_w;
endmodule

// File: doc/ras_repair_ctrl.md
RAS_REPAIR_CTRL -- requirements
Module: ras_repair_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8: checkpoint entries; power of two; tag width TW = log2(DEPTH) = 3.
REQ-002 SHALL have port clock, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port alloc_vld_i, input, 1: fetch requests a checkpoint for a predicted branch.
REQ-005 SHALL have port ras_ptr_i, input, 4: current RAS pointer to checkpoint.
REQ-006 SHALL have port ras_top_i, input, 64: current RAS top-of-stack data to checkpoint.
REQ-007 SHALL have port alloc_rdy_o, output, 1: checkpoint accepted this cycle.
REQ-008 SHALL have port alloc_tag_o, output, TW: tag of the entry written this cycle.
REQ-009 SHALL have port retire_vld_i, input, 1: oldest checkpointed branch retired.
REQ-010 SHALL have port flush_vld_i, input, 1: mispredict/flush of branch flush_tag_i.
REQ-011 SHALL have port flush_tag_i, input, TW: tag of the mispredicted branch.
REQ-012 SHALL have port ras_wr_en_o, input-side write enable to RAS, output, 1.
REQ-013 SHALL have port ras_wr_idx_o, output, 4: RAS index to rewrite.
REQ-014 SHALL have port ras_wr_data_o, output, 64: data to rewrite.
REQ-015 SHALL have port ras_ptr_rst_vld_o, output, 1: force RAS pointer.
REQ-016 SHALL have port ras_ptr_rst_o, output, 4: pointer value to force.
REQ-017 SHALL have port busy_o, output, 1: repair in progress; fetch stalls.
REQ-018 SHALL have port count_o, output, TW+1: live checkpoint count, 0..DEPTH.

Function
REQ-019 SHALL hold checkpoints in a circular buffer with head/tail pointers of TW+1 bits (extra wrap bit); empty when head==tail, full when indices equal and wrap bits differ.
REQ-020 SHALL drive alloc_rdy_o = ~full & (state==IDLE) & ~flush_vld_i, combinationally.
REQ-021 SHALL, when alloc_vld_i & alloc_rdy_o, write {ras_ptr_i, ras_top_i} at tail index, drive alloc_tag_o = tail index in that cycle, and increment tail (mod 2*DEPTH).
REQ-022 SHALL, when retire_vld_i and not empty, increment head; retire on empty SHALL be ignored.
REQ-023 SHALL implement FSM with states IDLE and REPAIR; IDLE->REPAIR on flush_vld_i with valid tag; REPAIR->IDLE unconditionally after one cycle.
REQ-024 SHALL deem a flush tag valid if it indexes a live entry (between head inclusive and tail exclusive, pre-retire pointers).
REQ-025 SHALL, on valid flush, latch the entry at flush_tag_i and set tail to the flushed entry's position +1 (younger checkpoints discarded; flushed entry retained).
REQ-026 SHALL, on invalid flush (including empty buffer), set tail=head, stay IDLE, and issue no RAS write.
REQ-027 SHALL, in REPAIR, assert ras_wr_en_o, ras_ptr_rst_vld_o and busy_o for exactly one cycle with ras_wr_idx_o = ras_ptr_rst_o = latched pointer, ras_wr_data_o = latched data; these outputs SHALL be 0 otherwise.
REQ-028 SHALL, on simultaneous retire and valid flush, apply both: head increments and tail is set per REQ-025; if flush_tag_i equals the head entry, the buffer becomes empty but repair still occurs.
REQ-029 SHALL ignore flush_vld_i during REPAIR (latched repair completes).
REQ-030 SHALL ignore alloc_vld_i while not ready; no entry written, tail unchanged.
REQ-031 SHALL drive count_o = tail - head (TW+1-bit modular arithmetic), registered-state derived.

Reset
REQ-032 SHALL, on reset_n low, asynchronously clear head, tail and FSM (IDLE); count_o=0, busy_o=0, ras_wr_en_o=0, ras_ptr_rst_vld_o=0, alloc_rdy_o=1 (when flush_vld_i low); entry storage need not be cleared.
REQ-033 SHALL abort an in-progress REPAIR on reset without issuing the RAS write.

Verification
REQ-034 Bench SHALL check: 8 allocs with ptrs 1..8 -> tags 0..7, count_o=8, alloc_rdy_o=0 on 9th request, tail unchanged.
REQ-035 Bench SHALL check: allocs ptr=3/data=0xA, ptr=5/data=0xB; flush tag 0 -> next cycle ras_wr_en_o=1, idx=3, data=0xA, ras_ptr_rst_o=3, busy_o=1 one cycle; count_o=1.
REQ-036 Bench SHALL check: wrap-around -- 6 allocs, 6 retires, 5 allocs -> tags 6,7,0,1,2; flush tag 7 -> repair with tag-7 data, count_o=2.
REQ-037 Bench SHALL check: flush with tag outside live range, or on empty buffer -> no repair pulse, count_o=0.
REQ-038 Bench SHALL check: retire and flush of head tag same cycle -> one repair pulse, count_o=0; alloc in flush cycle refused.
REQ-039 Bench SHALL check: reset_n asserted during REPAIR -> ras_wr_en_o drops immediately, count_o=0, FSM IDLE.
